// File: rtl/rsa_pkg.sv
// Shared types for the RSA datapath: exponentiation FSM states
// and the default operand width.
package rsa_pkg;

  localparam int RSA_WIDTH = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    CHECK  = 3'd2,
    MUL    = 3'd3,
    SQR    = 3'd4,
    SHIFT  = 3'd5,
    FINISH = 3'd6
  } exp_state_t;

endpackage

// File: rtl/mod_mult.sv
// Interleaved shift-add modular multiplier: product = a*b mod n.
// Walks a MSB-first; b must already be below n, a may be any value.
module mod_mult #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  logic [WIDTH+1:0] t, n1, n2;
  logic [WIDTH-1:0] sub;

  always_comb begin
    n1 = {2'b00, n_q};
    n2 = {1'b0, n_q, 1'b0};
    t  = {1'b0, p_q, 1'b0}
       + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
    // t < 3n, so at most one of n or 2n brings it below n
    if (t >= n2)      sub = n2[WIDTH-1:0];
    else if (t >= n1) sub = n_q;
    else              sub = '0;

    a_d    = a_q;
    b_d    = b_q;
    n_d    = n_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start && !run_q) begin
      a_d   = a;
      b_d   = b;
      n_d   = n;
      p_d   = '0;
      cnt_d = CW'(WIDTH);
      run_d = 1'b1;
    end else if (run_q) begin
      p_d   = t[WIDTH-1:0] - sub;
      a_d   = a_q << 1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      n_q    <= n_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign product = p_q;
  assign done    = done_q;

endmodule

// File: rtl/mod_exp_engine.sv
// Modular exponentiation m^e mod n, right-to-left square-and-multiply
// over one time-multiplexed mod_mult.
module mod_exp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH     = RSA_WIDTH,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     m,
  input  logic [EXP_WIDTH-1:0] e,
  input  logic [WIDTH-1:0]     n,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result
);

  exp_state_t           state_q, state_d;
  logic [WIDTH-1:0]     n_q, n_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 mm_start_q, mm_start_d;

  logic [WIDTH-1:0] mm_a, mm_b, mm_p;
  logic             mm_done;
  logic             mm_start;

  assign mm_start = mm_start_q;

  always_comb begin
    unique case (state_q)
      REDUCE:  begin mm_a = base_q; mm_b = WIDTH'(1); end
      MUL:     begin mm_a = acc_q;  mm_b = base_q;    end
      default: begin mm_a = base_q; mm_b = base_q;    end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    exp_d    = exp_q;
    acc_d    = acc_q;
    base_d   = base_q;
    result_d = result_q;
    busy_d   = busy_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          n_d      = n;
          exp_d    = e;
          acc_d    = WIDTH'(1);
          base_d   = m;
          busy_d   = 1'b1;
          result_d = '0;
          err_d    = (n == '0);
          if (n <= WIDTH'(1)) state_d = FINISH;
          else                state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (mm_done) begin
          base_d  = mm_p;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (exp_q == '0) begin
          result_d = acc_q;
          state_d  = FINISH;
        end else if (exp_q[0]) begin
          state_d = MUL;
        end else begin
          state_d = SQR;
        end
      end
      MUL: begin
        if (mm_done) begin
          acc_d = mm_p;
          // last set bit: the trailing square would be wasted
          if (exp_q[EXP_WIDTH-1:1] == '0) state_d = SHIFT;
          else                           state_d = SQR;
        end
      end
      SQR: begin
        if (mm_done) begin
          base_d  = mm_p;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        exp_d   = exp_q >> 1;
        state_d = CHECK;
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    done_d     = (state_d == FINISH);
    mm_start_d = (state_d != state_q) &&
                 ((state_d == REDUCE) ||
                  (state_d == MUL) ||
                  (state_d == SQR));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      exp_q      <= '0;
      acc_q      <= '0;
      base_q     <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mm_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      exp_q      <= exp_d;
      acc_q      <= acc_d;
      base_q     <= base_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mm_start_q <= mm_start_d;
    end
  end

  mod_mult #(.WIDTH(WIDTH)) u_mm (
    .clk     (clk),
    .reset   (reset),
    .start   (mm_start_q),
    .a       (mm_a),
    .b       (mm_b),
    .n       (n_q),
    .product (mm_p),
    .done    (mm_done)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule
